data_mem_pipe: RTL
==================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DEPTH_WORDS, default 8192, number of 32-bit words; SHALL be a power of two, 1024..65536.
REQ-002 Parameter READ_LATENCY, default 1, cycles from request accept to response; SHALL be legal only in the range 1..3.
REQ-003 Parameter INIT_FILE, default "", hex image loaded into memory at elaboration; SHALL leave contents unspecified when empty.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted on a cycle where req_valid and req_ready are both high.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed on a cycle where rsp_valid and rsp_ready are both high.
REQ-014 rsp_rdata  output  32  load data, extended per size; 0 for stores and errors.
REQ-015 rsp_err  output  1  request faulted.
REQ-016 err_count  output  16  saturating count of faulted requests.

Function
REQ-017 Pipeline: READ_LATENCY stages; each stage holds valid, size, byte offset, err, we.
REQ-018 Advance condition: pipeline SHALL advance when !rsp_valid || rsp_ready; req_ready SHALL equal the advance condition.
REQ-019 Stall: all stage registers and the memory read port SHALL hold unchanged when the pipeline does not advance.
REQ-020 Ordering: one response per accepted request, in order, exactly READ_LATENCY cycles after accept when there is no backpressure.
REQ-021 Fault on misalignment: H/HU with addr[0]=1, and W with addr[1:0]!=00.
REQ-022 Fault on illegal size: req_size 011, 110, 111, and 100/101 with req_we=1.
REQ-023 Fault on range: addr[31:2] >= DEPTH_WORDS.
REQ-024 Faulted request: memory SHALL NOT be written; rsp_err=1; rsp_rdata=0.
REQ-025 Store commit: byte-lane write on the accept edge; B writes lane addr[1:0], H writes lanes {addr[1],0} and {addr[1],1}, W writes all lanes; other lanes SHALL be unchanged.
REQ-026 Store response: rsp_rdata=0, rsp_err=0.
REQ-027 Load extraction: select byte or halfword by offset; B and H SHALL sign-extend, BU and HU SHALL zero-extend, W SHALL pass through.
REQ-028 Read-after-write: a load accepted the cycle after a store to the same word SHALL return the new data.
REQ-029 err_count SHALL increment by 1 when a faulted request is accepted, saturating at 16'hFFFF.
REQ-030 Address bits above log2(DEPTH_WORDS)+1 SHALL be used only for the range check.

Reset
REQ-031 On reset assertion: all stage valids, rsp_valid, rsp_err and err_count SHALL clear to 0 and rsp_rdata to 32'h0 immediately (asynchronously).
REQ-032 req_ready SHALL be 1 while reset is asserted and on the first cycle after release.
REQ-033 Memory contents SHALL NOT be altered by reset; stores accepted before reset stay committed.
REQ-034 In-flight loads SHALL be dropped with no response.

Verification
REQ-035 Scenario: LATENCY=1; SW 0x8765_43A1 to 0x100, then LB 0x100 -> rsp_rdata=0xFFFF_FFA1; LBU 0x100 -> 0x0000_00A1; LHU 0x102 -> 0x0000_8765; LH 0x102 -> 0xFFFF_8765.
REQ-036 Scenario: SB 0x5A to 0x103 over word 0x8765_43A1 -> LW 0x100 returns 0x5A65_43A1.
REQ-037 Scenario: LW 0x102, SH 0x101, and LW at byte address 4*DEPTH_WORDS -> each response has rsp_err=1 and rsp_rdata=0, err_count=3, memory unchanged.
REQ-038 Scenario: LATENCY=3; back-to-back loads with rsp_ready low for 4 cycles -> req_ready low for those 4 cycles, responses held stable, no loss or duplication, original order preserved.
REQ-039 Scenario: reset pulsed with 2 loads in flight -> no responses for them, err_count=0, and a prior store still readable afterwards.
REQ-040 Scenario: 65540 faulted requests -> err_count saturates at 0xFFFF.

Source files
------------

// File: rtl/data_mem_pipe.sv
// Byte-addressable RV32I data memory behind a READ_LATENCY-deep valid/ready pipeline.
// Detects misaligned, illegal-size and out-of-range requests. READ_LATENCY must be 1..3.
`timescale 1ns/1ps
module data_mem_pipe #(
    parameter int    DEPTH_WORDS  = 8192,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] err_count
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       err;
        logic [2:0] size;
        logic [1:0] off;
    } stage_t;

    stage_t         stg  [READ_LATENCY];
    logic [31:0]    word [READ_LATENCY];
    logic [31:0]    mem  [DEPTH_WORDS];

    logic           advance;
    logic           accept;
    logic           size_bad;
    logic           misalign;
    logic           fault;
    logic [AW-1:0]  idx;
    logic [3:0]     be;
    logic [31:0]    wd;
    stage_t         last;
    logic [31:0]    last_word;
    logic [31:0]    shifted;
    logic [15:0]    half_sel;
    logic [31:0]    ext;

    assign advance   = !rsp_valid || rsp_ready;
    assign req_ready = advance;
    assign accept    = req_valid && advance;
    assign idx       = req_addr[AW+1:2];

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        size_bad = 1'b0;
        misalign = 1'b0;
        case (req_size)
            3'b000:  ;
            3'b001:  misalign = req_addr[0];
            3'b010:  misalign = |req_addr[1:0];
            3'b100:  size_bad = req_we;
            3'b101:  begin size_bad = req_we; misalign = req_addr[0]; end
            default: size_bad = 1'b1;
        endcase
    end

    // Address bits above the word index only matter for the range check.
    assign fault = size_bad || misalign || (|req_addr[31:AW+2]);

    always_comb begin
        be = 4'b1111;
        wd = req_wdata;
        case (req_size[1:0])
            2'b00:   begin be = 4'b0001 << req_addr[1:0]; wd = {4{req_wdata[7:0]}}; end
            2'b01:   begin be = req_addr[1] ? 4'b1100 : 4'b0011; wd = {2{req_wdata[15:0]}}; end
            default: ;
        endcase
        if (!(accept && req_we && !fault)) be = 4'b0000;
    end

    // NOTE: the memory array and its read-data registers carry no reset; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
    end

    // Read-before-write on the same edge; a load one cycle after a store sees the new word.
    always_ff @(posedge clk) begin
        if (advance) begin
            word[0] <= mem[idx];
            for (int i = 1; i < READ_LATENCY; i++) word[i] <= word[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) stg[i] <= '0;
            err_count <= '0;
        end else begin
            if (advance) begin
                stg[0] <= '{valid: req_valid, we: req_we, err: fault,
                            size: req_size, off: req_addr[1:0]};
                for (int i = 1; i < READ_LATENCY; i++) stg[i] <= stg[i-1];
            end
            if (accept && fault && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        end
    end

    assign last      = stg[READ_LATENCY-1];
    assign last_word = word[READ_LATENCY-1];
    assign shifted   = last_word >> {last.off, 3'b000};
    assign half_sel  = last.off[1] ? last_word[31:16] : last_word[15:0];

    always_comb begin
        case (last.size)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, half_sel};
            default: ext = last_word;
        endcase
    end

    // Gating on valid makes the response outputs clear as soon as reset clears the stages.
    assign rsp_valid = last.valid;
    assign rsp_err   = last.valid && last.err;
    assign rsp_rdata = (last.valid && !last.err && !last.we) ? ext : 32'h0;

endmodule
